pipe_stage_reg: RTL and testbench

Parametrised, elastic pipeline stage register that replaces the fixed-field, stall-driven inter-stage registers between pipeline stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It carries a generic payload split into a "keep" field (pc, inst, valid-style metadata) and a "ctrl" field (control signals and operands). Transfer uses a valid/ready handshake with a 2-entry skid buffer, so full throughput is kept without a combinational ready path. Flush and exception squash are supported, and an exception keeps the keep field while zeroing the ctrl field.

---
 rtl/pipe_stage_reg.sv | 151 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake with a 2-entry skid buffer.
// Optional performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int KEEP_W = 160,
  parameter int CTRL_W = 256,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_exc,
  input  logic [KEEP_W-1:0] in_keep,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_exc,
  output logic [KEEP_W-1:0] out_keep,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // state | meaning
  // EMPTY | no entry held
  // ONE   | main entry valid, skid empty
  // FULL  | main and skid both valid, upstream stalled
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_next;

  logic              main_exc, skid_exc;
  logic [KEEP_W-1:0] main_keep, skid_keep;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [CTRL_W-1:0] in_ctrl_sq;

  logic acc, fire;
  logic load_main, load_skid, move_skid, drop_main;

  // Valid bits live in the occupancy encoding, so in_ready is a pure state decode.
  assign out_valid  = (state != EMPTY);
  assign in_ready   = (state != FULL) & ~rst;
  assign acc        = in_valid & in_ready;
  assign fire       = out_valid & out_ready;
  assign in_ctrl_sq = in_exc ? '0 : in_ctrl;

  assign out_exc  = main_exc;
  assign out_keep = main_keep;
  assign out_ctrl = main_ctrl;

  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    drop_main  = 1'b0;
    if (!(rst || flush)) begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state_next = ONE;
            load_main  = 1'b1;
          end
        end
        ONE: begin
          if (acc && fire) begin
            load_main = 1'b1;
          end else if (acc) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end else if (fire) begin
            state_next = EMPTY;
            drop_main  = 1'b1;
          end
        end
        FULL: begin
          if (fire) begin
            state_next = ONE;
            move_skid  = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end else begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= EMPTY;
      main_exc  <= 1'b0;
      main_keep <= '0;
      main_ctrl <= '0;
      skid_exc  <= 1'b0;
      skid_keep <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_next;
      if (load_main) begin
        main_exc  <= in_exc;
        main_keep <= in_keep;
        main_ctrl <= in_ctrl_sq;
      end else if (move_skid) begin
        main_exc  <= skid_exc;
        main_keep <= skid_keep;
        main_ctrl <= skid_ctrl;
      end else if (drop_main) begin
        main_exc  <= 1'b0;
        main_keep <= '0;
        main_ctrl <= '0;
      end
      if (load_skid) begin
        skid_exc  <= in_exc;
        skid_keep <= in_keep;
        skid_ctrl <= in_ctrl_sq;
      end else if (move_skid) begin
        skid_exc  <= 1'b0;
        skid_keep <= '0;
        skid_ctrl <= '0;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q, bubble_q;

  // Counters survive flush; only rst clears them. Both saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (!out_valid && (bubble_q != '1)) bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: FIFO-queue reference model checked every cycle plus directed literal checks.
// Counter expectations follow PIPE_STAGE_PERF_EN.
module tb_pipe_stage_reg;
  localparam int KW = 32;
  localparam int CW = 64;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, in_exc, out_valid, out_ready, out_exc;
  logic [KW-1:0] in_keep, out_keep;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [NW-1:0] stall_cnt, bubble_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.KEEP_W(KW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_exc(in_exc),
    .in_keep(in_keep), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_exc(out_exc),
    .out_keep(out_keep), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          exc;
    logic [KW-1:0] keep;
    logic [CW-1:0] ctrl;
  } ent_t;

  ent_t          q[$];
  logic [NW-1:0] m_stall = '0;
  logic [NW-1:0] m_bubble = '0;
`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of at most two entries, updated on each edge from pre-edge inputs.
  always @(posedge clk) begin
    bit   was_valid, acc, fire;
    ent_t e;
    was_valid = (q.size() > 0);
    if (rst) begin
      q.delete();
      m_stall  = '0;
      m_bubble = '0;
    end else begin
      if (was_valid && !out_ready && m_stall != '1) m_stall++;
      if (!was_valid && m_bubble != '1) m_bubble++;
      if (flush) begin
        q.delete();
      end else begin
        acc  = in_valid && (q.size() < 2);
        fire = was_valid && out_ready;
        if (fire) void'(q.pop_front());
        if (acc) begin
          e.exc  = in_exc;
          e.keep = in_keep;
          e.ctrl = in_exc ? '0 : in_ctrl;
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'((q.size() < 2) && !rst));
    if (q.size() > 0) begin
      chk("out_exc", 64'(out_exc), 64'(q[0].exc));
      chk("out_keep", 64'(out_keep), 64'(q[0].keep));
      chk("out_ctrl", out_ctrl, q[0].ctrl);
    end
    chk("stall_cnt", 64'(stall_cnt), PERF ? 64'(m_stall) : 64'd0);
    chk("bubble_cnt", 64'(bubble_cnt), PERF ? 64'(m_bubble) : 64'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic v, input logic [KW-1:0] k, input logic [CW-1:0] c,
                      input logic e, input logic ordy);
    in_valid  = v;
    in_keep   = k;
    in_ctrl   = c;
    in_exc    = e;
    out_ready = ordy;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    push(1'b0, '0, '0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_keep", 64'(out_keep), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // streaming at full rate
    push(1'b1, 32'h1, 64'h101, 1'b0, 1'b1); tick();
    chk("stream_1", 64'(out_keep), 64'h1);
    push(1'b1, 32'h2, 64'h102, 1'b0, 1'b1); tick();
    chk("stream_2", 64'(out_keep), 64'h2);
    chk("stream_ready", 64'(in_ready), 64'd1);
    push(1'b1, 32'h3, 64'h103, 1'b0, 1'b1); tick();
    chk("stream_3", 64'(out_keep), 64'h3);
    push(1'b0, '0, '0, 1'b0, 1'b1); tick();
    chk("stream_drain", 64'(out_valid), 64'd0);

    // backpressure fills the skid; 0xC waits upstream
    push(1'b1, 32'hA, 64'hA0, 1'b0, 1'b0); tick();
    push(1'b1, 32'hB, 64'hB0, 1'b0, 1'b0); tick();
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    chk("bp_head", 64'(out_keep), 64'hA);
    push(1'b1, 32'hC, 64'hC0, 1'b0, 1'b0); tick();
    chk("bp_hold", 64'(out_keep), 64'hA);
    push(1'b1, 32'hC, 64'hC0, 1'b0, 1'b1); tick();
    chk("bp_out_b", 64'(out_keep), 64'hB);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    tick();
    chk("bp_out_c", 64'(out_keep), 64'hC);
    push(1'b0, '0, '0, 1'b0, 1'b1); tick();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // exception squashes ctrl but keeps keep
    push(1'b1, 32'h8000_0000, '1, 1'b1, 1'b0); tick();
    chk("exc_keep", 64'(out_keep), 64'h8000_0000);
    chk("exc_ctrl", out_ctrl, 64'd0);
    chk("exc_flag", 64'(out_exc), 64'd1);
    push(1'b0, '0, '0, 1'b0, 1'b1); tick();

    // flush while FULL with an input offered
    push(1'b1, 32'h11, 64'h1, 1'b0, 1'b0); tick();
    push(1'b1, 32'h22, 64'h2, 1'b0, 1'b0); tick();
    push(1'b1, 32'h33, 64'h3, 1'b0, 1'b0); flush = 1'b1; tick();
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_keep", 64'(out_keep), 64'd0);
    // flush in ONE discards a same-cycle accepted input
    push(1'b1, 32'h44, 64'h4, 1'b0, 1'b0); tick();
    push(1'b1, 32'h55, 64'h5, 1'b0, 1'b1); flush = 1'b1; tick();
    flush = 1'b0;
    chk("flush_acc_valid", 64'(out_valid), 64'd0);
    push(1'b0, '0, '0, 1'b0, 1'b1); tick();

    // reset mid-stream with entries held
    push(1'b1, 32'h66, 64'h6, 1'b0, 1'b0); tick();
    push(1'b1, 32'h77, 64'h7, 1'b0, 1'b0); tick();
    rst = 1'b1; tick();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_keep", 64'(out_keep), 64'd0);
    chk("midrst_stall", 64'(stall_cnt), 64'd0);
    chk("midrst_bubble", 64'(bubble_cnt), 64'd0);
    push(1'b0, '0, '0, 1'b0, 1'b0); rst = 1'b0;

    // counters: 3 idle cycles, then 5 stalled cycles
    tick(); tick(); tick();
    chk("bubble_3", 64'(bubble_cnt), PERF ? 64'd3 : 64'd0);
    push(1'b1, 32'h99, 64'h9, 1'b0, 1'b0); tick();
    push(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("stall_5", 64'(stall_cnt), PERF ? 64'd5 : 64'd0);
    chk("bubble_4", 64'(bubble_cnt), PERF ? 64'd4 : 64'd0);

    // mixed traffic, checked by the model every cycle
    for (int i = 0; i < 400; i++) begin
      push(1'($urandom_range(0, 1)), KW'($urandom), {$urandom, $urandom},
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; flush = 1'b0;
    push(1'b0, '0, '0, 1'b0, 1'b1);
    tick(); tick(); tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
